// File: rtl/tqvp_vga_capture_pkg.sv
// Shared constants for the VGA line capture peripheral: register map,
// FSM state encoding and capture length.
package tqvp_vga_capture_pkg;

   localparam logic [5:0] ADDR_CTRL    = 6'h00;
   localparam logic [5:0] ADDR_TARGET  = 6'h04;
   localparam logic [5:0] ADDR_XOFF    = 6'h08;
   localparam logic [5:0] ADDR_SDIV    = 6'h0C;
   localparam logic [5:0] ADDR_HPERIOD = 6'h10;
   localparam logic [5:0] ADDR_VLINES  = 6'h14;
   localparam logic [5:0] ADDR_DATA0   = 6'h20;
   localparam logic [5:0] ADDR_DATA1   = 6'h24;
   localparam logic [5:0] ADDR_DATA2   = 6'h28;
   localparam logic [5:0] ADDR_DATA3   = 6'h2C;

   localparam int unsigned PIXEL_COUNT = 64;
   localparam logic [5:0]  PIX_LAST    = 6'(PIXEL_COUNT - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARMED     = 3'd1,
      ST_WAIT_LINE = 3'd2,
      ST_WAIT_X    = 3'd3,
      ST_CAPTURE   = 3'd4,
      ST_DONE      = 3'd5
   } state_t;

endpackage

// File: rtl/tqvp_vga_capture_vga_sync_edge.sv
// Sync falling-edge detection and line counter. With VGA_CAPTURE_MEASURE_EN
// defined it also measures the hsync period and the lines per frame.
module vga_sync_edge (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_hsync_n,
   input  logic        i_vsync_n,
   output logic        o_hs_start,
   output logic        o_vs_start,
   output logic [9:0]  o_line_nxt,
   output logic [11:0] o_hperiod,
   output logic [10:0] o_vlines
);

   logic       r_hs_d;
   logic       r_vs_d;
   logic [9:0] r_line;

   assign o_hs_start = r_hs_d & ~i_hsync_n;
   assign o_vs_start = r_vs_d & ~i_vsync_n;

   // Value the line counter takes this cycle; the FSM compares against it.
   always_comb begin
      o_line_nxt = r_line;
      if (o_vs_start)
         o_line_nxt = '0;
      else if (o_hs_start && r_line != 10'h3FF)
         o_line_nxt = r_line + 10'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hs_d <= 1'b0;
         r_vs_d <= 1'b0;
         r_line <= '0;
      end else begin
         r_hs_d <= i_hsync_n;
         r_vs_d <= i_vsync_n;
         r_line <= o_line_nxt;
      end
   end

`ifdef VGA_CAPTURE_MEASURE_EN
   logic [11:0] r_hcnt;
   logic [11:0] r_hperiod;
   logic [10:0] r_vlines;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hcnt    <= '0;
         r_hperiod <= '0;
         r_vlines  <= '0;
      end else begin
         if (o_hs_start) begin
            r_hcnt    <= 12'd1;
            r_hperiod <= r_hcnt;
         end else if (r_hcnt != 12'hFFF) begin
            r_hcnt <= r_hcnt + 12'd1;
         end
         if (o_vs_start)
            r_vlines <= {1'b0, r_line};
      end
   end

   assign o_hperiod = r_hperiod;
   assign o_vlines  = r_vlines;
`else
   assign o_hperiod = '0;
   assign o_vlines  = '0;
`endif

endmodule

// File: rtl/tqvp_vga_capture.sv
// TinyQV peripheral capturing 64 2-bit pixels from a chosen VGA line.
// Optional sync measurement (HPERIOD/VLINES) under VGA_CAPTURE_MEASURE_EN.
//
// state      | meaning
// IDLE       | not capturing
// ARMED      | waiting for start of frame (vsync start)
// WAIT_LINE  | counting hsync starts until TARGET_LINE
// WAIT_X     | X_OFFSET down-count after the target hsync start
// CAPTURE    | sampling pixels every SAMPLE_DIV+1 clocks
// DONE       | finished (done, optionally error), waits for arm
module tqvp_vga_capture
   import tqvp_vga_capture_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ui_in,
   output logic [7:0]  uo_out,
   input  logic [5:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   output logic        user_interrupt
);

   state_t       r_state, w_state_nxt;
   logic [9:0]   r_target;
   logic [10:0]  r_xoff, r_xcnt;
   logic [3:0]   r_sdiv, r_divcnt;
   logic [5:0]   r_pix;
   logic [127:0] r_data;
   logic         r_done, r_error, r_irq;

   logic         w_wr, w_rd, w_ctrl_wr, w_arm, w_abort;
   logic         w_hs_start, w_vs_start, w_line_hit, w_sample;
   logic         w_cfg_lock, w_enter_done, w_err_evt;
   logic [9:0]   w_line_nxt;
   logic [11:0]  w_hperiod;
   logic [10:0]  w_vlines;
   logic         w_unused;

   vga_sync_edge u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_hsync_n  (ui_in[0]),
      .i_vsync_n  (ui_in[1]),
      .o_hs_start (w_hs_start),
      .o_vs_start (w_vs_start),
      .o_line_nxt (w_line_nxt),
      .o_hperiod  (w_hperiod),
      .o_vlines   (w_vlines)
   );

   assign w_wr       = (data_write_n != 2'b11);
   assign w_rd       = (data_read_n != 2'b11);
   assign w_ctrl_wr  = w_wr && (address == ADDR_CTRL);
   assign w_abort    = w_ctrl_wr && data_in[1];
   assign w_arm      = w_ctrl_wr && data_in[0] && !data_in[1];
   assign w_line_hit = w_hs_start && (w_line_nxt == r_target);
   assign w_sample   = (r_state == ST_CAPTURE) && (r_divcnt == '0);
   assign w_cfg_lock = (r_state == ST_WAIT_X) || (r_state == ST_CAPTURE);

   always_comb begin
      w_state_nxt = r_state;
      w_err_evt   = 1'b0;
      if (w_abort)
         w_state_nxt = ST_IDLE;
      else if (w_arm)
         w_state_nxt = ST_ARMED;
      else begin
         case (r_state)
            ST_ARMED:     if (w_vs_start) w_state_nxt = ST_WAIT_LINE;
            ST_WAIT_LINE: if (w_line_hit)
                             w_state_nxt = (r_xoff == '0) ? ST_CAPTURE : ST_WAIT_X;
            ST_WAIT_X: begin
               if (w_vs_start) begin
                  w_state_nxt = ST_DONE;
                  w_err_evt   = 1'b1;
               end else if (r_xcnt == '0) begin
                  w_state_nxt = ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               if (w_vs_start) begin
                  w_state_nxt = ST_DONE;
                  w_err_evt   = 1'b1;
               end else if (w_sample && r_pix == PIX_LAST) begin
                  w_state_nxt = ST_DONE;
               end
            end
            ST_IDLE, ST_DONE: ;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign w_enter_done = (w_state_nxt == ST_DONE) && (r_state != ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_target <= '0;
         r_xoff   <= '0;
         r_sdiv   <= '0;
         r_xcnt   <= '0;
         r_divcnt <= '0;
         r_pix    <= '0;
         r_data   <= '0;
         r_done   <= 1'b0;
         r_error  <= 1'b0;
         r_irq    <= 1'b0;
      end else begin
         if (w_wr && !w_cfg_lock) begin
            case (address)
               ADDR_TARGET: r_target <= data_in[9:0];
               ADDR_XOFF:   r_xoff   <= data_in[10:0];
               ADDR_SDIV:   r_sdiv   <= data_in[3:0];
               default: ;
            endcase
         end

         if (r_state == ST_WAIT_LINE)
            r_xcnt <= r_xoff - 11'd1;
         else if (r_state == ST_WAIT_X && r_xcnt != '0)
            r_xcnt <= r_xcnt - 11'd1;

         // First sample lands on the CAPTURE entry cycle, then every SAMPLE_DIV+1.
         if (r_state != ST_CAPTURE) begin
            r_divcnt <= '0;
            r_pix    <= '0;
         end else if (w_sample) begin
            r_data[{r_pix, 1'b0} +: 2] <= ui_in[3:2];
            r_pix    <= r_pix + 6'd1;
            r_divcnt <= r_sdiv;
         end else begin
            r_divcnt <= r_divcnt - 4'd1;
         end

         if (w_arm) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_irq   <= 1'b0;
            r_data  <= '0;
         end else if (w_enter_done) begin
            r_done  <= 1'b1;
            r_error <= w_err_evt;
            r_irq   <= 1'b1;
         end else if (w_rd && address == ADDR_CTRL) begin
            r_irq <= 1'b0;
         end
      end
   end

   always_comb begin
      data_out = '0;
      case (address)
         ADDR_CTRL:    data_out = {27'b0, r_state, r_error, r_done};
         ADDR_TARGET:  data_out = {22'b0, r_target};
         ADDR_XOFF:    data_out = {21'b0, r_xoff};
         ADDR_SDIV:    data_out = {28'b0, r_sdiv};
         ADDR_HPERIOD: data_out = {20'b0, w_hperiod};
         ADDR_VLINES:  data_out = {21'b0, w_vlines};
         ADDR_DATA0:   data_out = r_data[31:0];
         ADDR_DATA1:   data_out = r_data[63:32];
         ADDR_DATA2:   data_out = r_data[95:64];
         ADDR_DATA3:   data_out = r_data[127:96];
         default: ;
      endcase
   end

   assign uo_out         = 8'h00;
   assign data_ready     = 1'b1;
   assign user_interrupt = r_irq;
   assign w_unused       = &{1'b0, ui_in[7:4], data_in[31:11]};

endmodule
